bf_prog_loader: RTL

//  UART-driven program loader sitting upstream of the program RAM write port and the CPU reset.

---
 rtl/bf_prog_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bf_prog_loader.sv
// UART-fed Brainfuck program loader: translates source characters into 4-bit opcodes,
// writes them to program RAM, terminates the program with HALT, and releases the CPU once brackets balance.
module bf_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int NEST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_reload,
  output logic [ADDR_W-1:0] o_prog_address,
  output logic [3:0]        o_prog_data,
  output logic              o_prog_wren,
  output logic              o_cpu_rst_n,
  output logic              o_loading,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_prog_len
);

  typedef enum logic [1:0] {S_LOAD, S_TERM, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_OPEN  = 4'd7;
  localparam logic [3:0] OP_CLOSE = 4'd8;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [NEST_W-1:0]   nest, nest_n;
  logic [ADDR_W:0]     len_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [3:0]          wr_data_n;
  logic                wren_n;

  logic [3:0]          op;
  logic                is_op;
  logic                is_term;

  // Character decode; anything not listed is whitespace/comment and produces no write.
  always_comb begin
    op      = OP_HALT;
    is_op   = 1'b1;
    is_term = 1'b0;
    unique case (i_rx_byte)
      8'h3E:        op = 4'd1;   // '>'
      8'h3C:        op = 4'd2;   // '<'
      8'h2B:        op = 4'd3;   // '+'
      8'h2D:        op = 4'd4;   // '-'
      8'h2E:        op = 4'd5;   // '.'
      8'h2C:        op = 4'd6;   // ','
      8'h5B:        op = OP_OPEN;
      8'h5D:        op = OP_CLOSE;
      8'h21, 8'h00: begin is_op = 1'b0; is_term = 1'b1; end
      default:      is_op = 1'b0;
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    addr_n    = addr;
    nest_n    = nest;
    len_n     = o_prog_len;
    wr_addr_n = o_prog_address;
    wr_data_n = o_prog_data;
    wren_n    = 1'b0;

    unique case (state)
      S_LOAD: begin
        if (i_rx_dv && is_term) begin
          // HALT goes out while in TERM; addr stays so prog_len excludes it.
          state_n   = S_TERM;
          wren_n    = 1'b1;
          wr_addr_n = addr;
          wr_data_n = OP_HALT;
        end else if (i_rx_dv && is_op) begin
          if (addr == LAST_ADDR ||
              (op == OP_OPEN  && nest == '1) ||
              (op == OP_CLOSE && nest == '0)) begin
            state_n = S_ERROR;
          end else begin
            wren_n    = 1'b1;
            wr_addr_n = addr;
            wr_data_n = op;
            addr_n    = addr + ADDR_W'(1);
            len_n     = o_prog_len + (ADDR_W+1)'(1);
            if (op == OP_OPEN)  nest_n = nest + NEST_W'(1);
            if (op == OP_CLOSE) nest_n = nest - NEST_W'(1);
          end
        end
      end
      S_TERM: state_n = (nest == '0) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: begin
        if (i_reload) begin
          state_n = S_LOAD;
          addr_n  = '0;
          nest_n  = '0;
          len_n   = '0;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_LOAD;
      addr           <= '0;
      nest           <= '0;
      o_prog_len     <= '0;
      o_prog_address <= '0;
      o_prog_data    <= '0;
      o_prog_wren    <= 1'b0;
    end else begin
      state          <= state_n;
      addr           <= addr_n;
      nest           <= nest_n;
      o_prog_len     <= len_n;
      o_prog_address <= wr_addr_n;
      o_prog_data    <= wr_data_n;
      o_prog_wren    <= wren_n;
    end
  end

  // Status decodes straight from the state register, so the CPU is released only after HALT landed.
  assign o_cpu_rst_n = (state == S_DONE);
  assign o_done      = (state == S_DONE);
  assign o_error     = (state == S_ERROR);
  assign o_loading   = (state == S_LOAD) || (state == S_TERM);

endmodule
